// File: rtl/arb_sched_pkg.sv
// rtl/arb_sched_pkg.sv - owner codes, FSM states and round-robin helper for arb_rr_burst_sched
package arb_sched_pkg;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_A    = 2'd1;
  localparam logic [1:0] OWN_B    = 2'd2;
  localparam logic [1:0] OWN_C    = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_t;

  // Next requester in rotation; C and NONE both wrap to A.
  function automatic logic [1:0] rr_next(input logic [1:0] owner);
    case (owner)
      OWN_A:   rr_next = OWN_B;
      OWN_B:   rr_next = OWN_C;
      default: rr_next = OWN_A;
    endcase
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - combinational 3-way rotating-priority picker
// ptr holds the owner code (A/B/C) searched first; NONE behaves as A.
module arb_rr_pick
  import arb_sched_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic       any
);

  always_comb begin
    gnt = 3'b000;
    case (ptr)
      OWN_B: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      OWN_C: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

  assign any = |req;

endmodule

// File: rtl/arb_rr_burst_sched.sv
// rtl/arb_rr_burst_sched.sv - round-robin burst scheduler, three sources onto one registered channel
// Optional per-source beat counters are built when ARB_STATS_EN is defined.
module arb_rr_burst_sched
  import arb_sched_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             SynReset,
  input  logic             i_DataValid_A,
  input  logic             i_DataValid_B,
  input  logic             i_DataValid_C,
  input  logic [WIDTH-1:0] i_DataIn_A,
  input  logic [WIDTH-1:0] i_DataIn_B,
  input  logic [WIDTH-1:0] i_DataIn_C,
  output logic             o_DataGrant_A,
  output logic             o_DataGrant_B,
  output logic             o_DataGrant_C,
  output logic             o_DataValid_D,
  output logic [WIDTH-1:0] o_DataOut_D,
  input  logic             i_DataGrant_D,
`ifdef ARB_STATS_EN
  output logic [CNT_W-1:0] o_BeatCnt_A,
  output logic [CNT_W-1:0] o_BeatCnt_B,
  output logic [CNT_W-1:0] o_BeatCnt_C,
`endif
  output logic [1:0]       o_Owner
);

  state_t            state;
  logic [1:0]        owner;
  logic [1:0]        ptr;
  logic [CNT_W-1:0]  beat_cnt;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;

  logic [2:0]        valid_vec;
  logic [2:0]        grant_vec;
  logic              can_load;
  logic              burst_grant;
  logic              owner_valid;
  logic [WIDTH-1:0]  sel_data;
  logic              xfer;
  logic              last_beat;
  logic              release_now;
  logic [1:0]        pick_ptr;
  logic [2:0]        pick_gnt;
  logic              pick_any;
  logic [1:0]        pick_owner;

  assign valid_vec   = {i_DataValid_C, i_DataValid_B, i_DataValid_A};
  assign can_load    = !out_valid || i_DataGrant_D;
  assign burst_grant = (state == ST_BURST) && can_load;
  assign grant_vec   = {burst_grant && (owner == OWN_C),
                        burst_grant && (owner == OWN_B),
                        burst_grant && (owner == OWN_A)};

  always_comb begin
    owner_valid = 1'b0;
    sel_data    = i_DataIn_A;
    case (owner)
      OWN_A: begin owner_valid = i_DataValid_A; sel_data = i_DataIn_A; end
      OWN_B: begin owner_valid = i_DataValid_B; sel_data = i_DataIn_B; end
      OWN_C: begin owner_valid = i_DataValid_C; sel_data = i_DataIn_C; end
      default: ;
    endcase
  end

  assign xfer        = burst_grant && owner_valid;
  assign last_beat   = (beat_cnt == CNT_W'(BURST_LEN - 1));
  assign release_now = (state == ST_BURST) && ((xfer && last_beat) || !owner_valid);

  // One picker serves both paths: IDLE searches from ptr, a release searches from owner+1
  // so the outgoing owner comes last and can keep the channel only if nobody else waits.
  assign pick_ptr = (state == ST_BURST) ? rr_next(owner) : ptr;

  arb_rr_pick u_pick (
    .req (valid_vec),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  assign pick_owner = pick_gnt[0] ? OWN_A :
                      pick_gnt[1] ? OWN_B :
                      pick_gnt[2] ? OWN_C : OWN_NONE;

  always_ff @(posedge CLK) begin
    if (SynReset) begin
      state     <= ST_IDLE;
      owner     <= OWN_NONE;
      ptr       <= OWN_A;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (xfer) begin
        out_data  <= sel_data;
        out_valid <= 1'b1;
      end else if (i_DataGrant_D) begin
        out_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            owner    <= pick_owner;
            beat_cnt <= '0;
            state    <= ST_BURST;
          end
        end
        default: begin
          if (release_now) begin
            ptr      <= rr_next(owner);
            beat_cnt <= '0;
            if (pick_any) begin
              owner <= pick_owner;
            end else begin
              owner <= OWN_NONE;
              state <= ST_IDLE;
            end
          end else if (xfer) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign o_DataGrant_A = grant_vec[0];
  assign o_DataGrant_B = grant_vec[1];
  assign o_DataGrant_C = grant_vec[2];
  assign o_DataValid_D = out_valid;
  assign o_DataOut_D   = out_data;
  assign o_Owner       = owner;

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] src_cnt [3];

  always_ff @(posedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (SynReset)
        src_cnt[i] <= '0;
      else if (grant_vec[i] && valid_vec[i] && (src_cnt[i] != {CNT_W{1'b1}}))
        src_cnt[i] <= src_cnt[i] + CNT_W'(1);
    end
  end

  assign o_BeatCnt_A = src_cnt[0];
  assign o_BeatCnt_B = src_cnt[1];
  assign o_BeatCnt_C = src_cnt[2];
`endif

endmodule

// File: tb/tb_arb_rr_burst_sched.sv
// tb/tb_arb_rr_burst_sched.sv - self-checking bench for arb_rr_burst_sched
// Stats checks are compiled in when ARB_STATS_EN is defined.
module tb_arb_rr_burst_sched;

  localparam int WIDTH     = 64;
  localparam int BURST_LEN = 4;
  localparam int CNT_W     = 8;

  logic             CLK = 1'b0;
  logic             SynReset;
  logic             va, vb, vc;
  logic [WIDTH-1:0] da, db, dc;
  logic             ga, gb, gc;
  logic             dv_out;
  logic [WIDTH-1:0] dout;
  logic             dgrant;
  logic [1:0]       owner;
`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] ca, cb, cc;
  logic [2:0]       sa, sb, sc;
  logic             g3a, g3b, g3c, dv3;
  logic [WIDTH-1:0] dout3;
  logic [1:0]       owner3;
`endif

  always #5 CLK = ~CLK;

  arb_rr_burst_sched #(.WIDTH(WIDTH), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .SynReset(SynReset),
    .i_DataValid_A(va), .i_DataValid_B(vb), .i_DataValid_C(vc),
    .i_DataIn_A(da), .i_DataIn_B(db), .i_DataIn_C(dc),
    .o_DataGrant_A(ga), .o_DataGrant_B(gb), .o_DataGrant_C(gc),
    .o_DataValid_D(dv_out), .o_DataOut_D(dout), .i_DataGrant_D(dgrant),
`ifdef ARB_STATS_EN
    .o_BeatCnt_A(ca), .o_BeatCnt_B(cb), .o_BeatCnt_C(cc),
`endif
    .o_Owner(owner)
  );

`ifdef ARB_STATS_EN
  arb_rr_burst_sched #(.WIDTH(WIDTH), .BURST_LEN(BURST_LEN), .CNT_W(3)) dut3 (
    .CLK(CLK), .SynReset(SynReset),
    .i_DataValid_A(va), .i_DataValid_B(vb), .i_DataValid_C(vc),
    .i_DataIn_A(da), .i_DataIn_B(db), .i_DataIn_C(dc),
    .o_DataGrant_A(g3a), .o_DataGrant_B(g3b), .o_DataGrant_C(g3c),
    .o_DataValid_D(dv3), .o_DataOut_D(dout3), .i_DataGrant_D(dgrant),
    .o_BeatCnt_A(sa), .o_BeatCnt_B(sb), .o_BeatCnt_C(sc),
    .o_Owner(owner3)
  );
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: owner 0 means idle, 1..3 are A..C.
  bit               m_init = 1'b0;
  int               m_owner, m_ptr, m_taken;
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_cnt [1:3];
  logic [WIDTH-1:0] sb_q [$];

  bit [3:1]         obs_gnt, obs_xfer;
  bit               obs_dv;
  logic [WIDTH-1:0] obs_dout;
  logic [1:0]       obs_owner;

  typedef struct {
    bit       rst;
    bit [2:0] v;
    bit       dg;
    bit [2:0] gnt;
    bit [1:0] own;
    bit       dv;
    bit [1:0] src;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int first_valid(input int start, input bit [3:1] v);
    int c;
    for (int k = 0; k < 3; k++) begin
      c = (start - 1 + k) % 3 + 1;
      if (v[c]) return c;
    end
    return 0;
  endfunction

  function automatic int sat(input int n, input int lim);
    return (n > lim) ? lim : n;
  endfunction

  task automatic drive_tagged();
    da = {32'd1, 32'(cyc)};
    db = {32'd2, 32'(cyc)};
    dc = {32'd3, 32'(cyc)};
  endtask

  task automatic step();
    bit [3:1]         v, eg, mx;
    bit               can_load, done;
    int               x;
    logic [WIDTH-1:0] din [1:3];
    @(negedge CLK);
    v = {vc, vb, va};
    din[1] = da; din[2] = db; din[3] = dc;
    obs_gnt   = {gc, gb, ga};
    obs_xfer  = obs_gnt & v;
    obs_dv    = dv_out;
    obs_dout  = dout;
    obs_owner = owner;
    eg = '0;
    if (m_init) begin
      can_load = !m_valid || dgrant;
      if (m_owner != 0 && can_load) eg[m_owner] = 1'b1;
      chk("grant", 64'(obs_gnt), 64'(eg));
      chk("owner", 64'(obs_owner), 64'(m_owner));
      chk("out_valid", 64'(obs_dv), 64'(m_valid));
      chk("out_data", obs_dout, m_data);
      if (m_valid && dgrant) begin
        if (sb_q.size() == 0) chk("sink_unexpected", 64'(1), 64'(0));
        else chk("sink_beat", obs_dout, sb_q.pop_front());
      end
`ifdef ARB_STATS_EN
      chk("cnt_a", 64'(ca), 64'(sat(m_cnt[1], 255)));
      chk("cnt_b", 64'(cb), 64'(sat(m_cnt[2], 255)));
      chk("cnt_c", 64'(cc), 64'(sat(m_cnt[3], 255)));
      chk("cnt3_a", 64'(sa), 64'(sat(m_cnt[1], 7)));
      chk("cnt3_b", 64'(sb), 64'(sat(m_cnt[2], 7)));
      chk("cnt3_c", 64'(sc), 64'(sat(m_cnt[3], 7)));
`endif
    end
    @(posedge CLK);
    if (SynReset) begin
      m_init = 1'b1; m_owner = 0; m_ptr = 1; m_taken = 0;
      m_valid = 1'b0; m_data = '0; sb_q.delete();
      for (int k = 1; k <= 3; k++) m_cnt[k] = 0;
    end else if (m_init) begin
      mx = eg & v;
      x = 0;
      for (int k = 1; k <= 3; k++) if (mx[k]) x = k;
      if (x != 0) begin
        m_data = din[x]; m_valid = 1'b1; sb_q.push_back(din[x]); m_cnt[x]++;
      end else if (dgrant) begin
        m_valid = 1'b0;
      end
      if (m_owner == 0) begin
        m_owner = first_valid(m_ptr, v);
        m_taken = 0;
      end else begin
        done = (x != 0 && m_taken + 1 == BURST_LEN) || !v[m_owner];
        if (x != 0) m_taken++;
        if (done) begin
          m_ptr   = m_owner % 3 + 1;
          m_owner = first_valid(m_ptr, v);
          m_taken = 0;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic add(input bit rst, input bit [2:0] v, input bit dg, input bit [2:0] gnt,
                     input int own, input bit dv, input int src);
    vec_t r;
    r.rst = rst; r.v = v; r.dg = dg; r.gnt = gnt;
    r.own = 2'(own); r.dv = dv; r.src = 2'(src);
    tbl.push_back(r);
  endtask

  initial begin
    int n, o, p;
    logic [WIDTH-1:0] held;
    bit seen;

    // Reset twice with all sources valid, fair rotation, then B alone across tenure boundaries.
    add(1, 3'b111, 1, 3'b000, 0, 0, 0);
    add(0, 3'b111, 1, 3'b000, 0, 0, 0);
    for (int r = 2; r < 18; r++) begin
      o = ((r - 2) / 4) % 3 + 1;
      p = (r == 2) ? 0 : ((r - 3) / 4) % 3 + 1;
      add(0, 3'b111, 1, 3'(1 << (o - 1)), o, r != 2, p);
    end
    for (int r = 18; r < 28; r++) add(0, 3'b010, 1, 3'b010, 2, 1, (r == 18) ? 1 : 2);
    add(0, 3'b000, 1, 3'b010, 2, 1, 2);
    add(0, 3'b000, 1, 3'b000, 0, 0, 0);

    SynReset = 1'b1; {vc, vb, va} = 3'b111; dgrant = 1'b1; drive_tagged();
    @(posedge CLK); #1;
    step();

    for (int i = 0; i < tbl.size(); i++) begin
      SynReset = tbl[i].rst; {vc, vb, va} = tbl[i].v; dgrant = tbl[i].dg; drive_tagged();
      step();
      chk($sformatf("tbl%0d_gnt", i), 64'(obs_gnt), 64'(tbl[i].gnt));
      chk($sformatf("tbl%0d_owner", i), 64'(obs_owner), 64'(tbl[i].own));
      chk($sformatf("tbl%0d_dv", i), 64'(obs_dv), 64'(tbl[i].dv));
      if (tbl[i].dv) chk($sformatf("tbl%0d_src", i), 64'(obs_dout[63:32]), 64'(tbl[i].src));
    end

    // Backpressure: stall three cycles after A's second beat.
    {vc, vb, va} = 3'b011; dgrant = 1'b1; n = 0; held = '0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      drive_tagged(); held = da; step();
      if (obs_xfer[1]) n++;
    end
    chk("t4_two_beats", 64'(n), 64'(2));
    dgrant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_tagged(); step();
      chk("t4_stall_gnt", 64'(obs_gnt), 64'(0));
      chk("t4_stall_valid", 64'(obs_dv), 64'(1));
      chk("t4_stall_data", obs_dout, held);
    end
    dgrant = 1'b1; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      drive_tagged(); step();
      if (obs_xfer[1]) n++;
      if (obs_gnt[2]) seen = 1'b1;
    end
    chk("t4_b_reached", 64'(seen), 64'(1));
    chk("t4_a_tenure_len", 64'(n), 64'(BURST_LEN));

    // Early release: A drops after two beats while C waits.
    {vc, vb, va} = 3'b000;
    for (int i = 0; i < 3; i++) begin drive_tagged(); step(); end
    {vc, vb, va} = 3'b001; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      drive_tagged(); step();
      if (obs_xfer[1]) seen = 1'b1;
    end
    chk("t5_a_first", 64'(seen), 64'(1));
    {vc, vb, va} = 3'b101; drive_tagged(); step();
    chk("t5_a_second", 64'(obs_xfer), 64'(3'b001));
    {vc, vb, va} = 3'b100; drive_tagged(); step();
    chk("t5_bubble_xfer", 64'(obs_xfer), 64'(0));
    {vc, vb, va} = 3'b101; drive_tagged(); step();
    chk("t5_c_grant", 64'(obs_gnt), 64'(3'b100));
    chk("t5_bubble_on_d", 64'(obs_dv), 64'(0));
    for (int i = 0; i < 3; i++) begin drive_tagged(); step(); end
    drive_tagged(); step();
    chk("t5_wrap_to_a", 64'(obs_gnt), 64'(3'b001));

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      SynReset = ($urandom_range(0, 299) == 0);
      va = ($urandom_range(0, 3) != 0);
      vb = ($urandom_range(0, 3) != 0);
      vc = ($urandom_range(0, 3) != 0);
      dgrant = ($urandom_range(0, 9) < 7);
      da = {$urandom, $urandom}; db = {$urandom, $urandom}; dc = {$urandom, $urandom};
      step();
    end
    SynReset = 1'b0;

`ifdef ARB_STATS_EN
    SynReset = 1'b1; {vc, vb, va} = 3'b000; dgrant = 1'b1; drive_tagged(); step();
    SynReset = 1'b0;
    {vc, vb, va} = 3'b001; n = 0;
    for (int i = 0; i < 40 && n < 5; i++) begin drive_tagged(); step(); if (obs_xfer[1]) n++; end
    {vc, vb, va} = 3'b010; n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin drive_tagged(); step(); if (obs_xfer[2]) n++; end
    {vc, vb, va} = 3'b000;
    for (int i = 0; i < 2; i++) begin drive_tagged(); step(); end
    chk("t6_cnt_a", 64'(ca), 64'(5));
    chk("t6_cnt_b", 64'(cb), 64'(3));
    chk("t6_cnt_c", 64'(cc), 64'(0));
    {vc, vb, va} = 3'b001; n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin drive_tagged(); step(); if (obs_xfer[1]) n++; end
    {vc, vb, va} = 3'b000; drive_tagged(); step();
    chk("t6_cnt_a9", 64'(ca), 64'(9));
    chk("t6_sat_a", 64'(sa), 64'(7));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
